// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the iterative multiply/divide unit.
//   Operation encodings, FSM state encoding, iteration count and
//   two's-complement negate helpers used by muldiv_unit and muldiv_iter.
package muldiv_pkg;

    localparam int MULDIV_STEPS = 32;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [31:0] neg32_if(input logic neg, input logic [31:0] val);
        return neg ? (~val + 32'd1) : val;
    endfunction

    function automatic logic [63:0] neg64_if(input logic neg, input logic [63:0] val);
        return neg ? (~val + 64'd1) : val;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- request/result bundle between pipeline and muldiv_unit.
//   Start/Op/A/B/Rd : request from the pipeline (master drives)
//   Busy            : unit occupied, stall request
//   Done            : one-cycle result-valid pulse
//   Result/WAdr/WE  : register-file write port (Din, WAdr, WE)
interface muldiv_if;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Rd;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [4:0]  WAdr;
    logic        WE;

    modport master (output Start, Op, A, B, Rd, input Busy, Done, Result, WAdr, WE);
    modport slave  (input Start, Op, A, B, Rd, output Busy, Done, Result, WAdr, WE);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter -- radix-2 iterative datapath on unsigned magnitudes.
//   Clk, Rst : clock, synchronous active-high reset
//   load     : capture opa (multiplier / dividend) and opb (multiplicand / divisor)
//   step     : advance one shift-add (multiply) or restoring-subtract (divide) step
//   is_div   : select divide step instead of multiply step
//   acc_next : accumulator value after the step about to be taken
//              multiply: 64-bit product; divide: {remainder, quotient}
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc_next
);
    logic [63:0] acc_r;
    logic [31:0] opb_r;
    logic [32:0] sum_s;
    logic [32:0] part_s;
    logic [32:0] sub_s;
    logic        fits_s;

    // One iteration step computed from the current accumulator
    always_comb begin
        sum_s    = 33'd0;
        part_s   = 33'd0;
        sub_s    = 33'd0;
        fits_s   = 1'b0;
        acc_next = acc_r;
        if (is_div) begin
            // Shifted partial remainder can reach 33 bits; a set top bit
            // means it certainly exceeds the 32-bit divisor.
            part_s = acc_r[63:31];
            sub_s  = {1'b0, part_s[31:0]} - {1'b0, opb_r};
            fits_s = part_s[32] | ~sub_s[32];
            if (fits_s) begin
                acc_next = {sub_s[31:0], acc_r[30:0], 1'b1};
            end else begin
                acc_next = {part_s[31:0], acc_r[30:0], 1'b0};
            end
        end else begin
            if (acc_r[0]) begin
                sum_s = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
            end else begin
                sum_s = {1'b0, acc_r[63:32]};
            end
            acc_next = {sum_s, acc_r[31:1]};
        end
    end

    // Accumulator and second-operand registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc_r <= 64'd0;
            opb_r <= 32'd0;
        end else if (load) begin
            acc_r <= {32'd0, opa};
            opb_r <= opb;
        end else if (step) begin
            acc_r <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- fixed-latency 32-bit multiply/divide unit (IDLE/CALC/DONE).
//   Clk : clock, all state changes on rising edge
//   Rst : synchronous active-high reset, priority over Start
//   bus : muldiv_if slave (Start/Op/A/B/Rd in; Busy/Done/Result/WAdr/WE out)
// Build option: define MULDIV_SIGNED_EN for two's-complement MULH/DIV/REM;
// without it those operations are unsigned (MULHU/DIVU/REMU).
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic    Clk,
    input  logic    Rst,
    muldiv_if.slave bus
);
    state_e      state_r, state_next_s;
    logic [4:0]  cnt_r, cnt_next_s;
    op_e         op_r;
    logic [4:0]  rd_r;
    logic [31:0] a_r;
    logic        neg_a_r, neg_b_r, b_zero_r;
    logic        busy_r, busy_next_s;
    logic        done_r, done_next_s;
    logic        we_r, we_next_s;
    logic [31:0] result_r;
    logic [4:0]  wadr_r;
    logic        sign_a_s, sign_b_s;
    logic [31:0] mag_a_s, mag_b_s;
    logic        load_s, step_s, last_s;
    logic [63:0] acc_next_s, prod_s;
    logic [31:0] quot_s, rem_s, final_s;

    // Operand signs and magnitudes fed to the unsigned datapath
    always_comb begin
`ifdef MULDIV_SIGNED_EN
        sign_a_s = bus.A[31];
        sign_b_s = bus.B[31];
`else
        sign_a_s = 1'b0;
        sign_b_s = 1'b0;
`endif
        mag_a_s = neg32_if(sign_a_s, bus.A);
        mag_b_s = neg32_if(sign_b_s, bus.B);
    end

    assign load_s = (state_r == IDLE) && bus.Start;
    assign step_s = (state_r == CALC);
    assign last_s = step_s && (cnt_r == 5'd0);

    muldiv_iter u_iter (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (load_s),
        .step     (step_s),
        .is_div   (op_r[1]),
        .opa      (mag_a_s),
        .opb      (mag_b_s),
        .acc_next (acc_next_s)
    );

    // Sign fix-up of the final step output, captured on entry to DONE
    always_comb begin
        prod_s = neg64_if(neg_a_r ^ neg_b_r, acc_next_s);
        quot_s = neg32_if(neg_a_r ^ neg_b_r, acc_next_s[31:0]);
        rem_s  = neg32_if(neg_a_r, acc_next_s[63:32]);
        case (op_r)
            OP_MUL:  final_s = prod_s[31:0];
            OP_MULH: final_s = prod_s[63:32];
            OP_DIV:  final_s = b_zero_r ? 32'hFFFF_FFFF : quot_s;
            OP_REM:  final_s = b_zero_r ? a_r : rem_s;
            default: final_s = 32'd0;
        endcase
    end

    // Next-state and next-output decode
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        busy_next_s  = 1'b0;
        done_next_s  = 1'b0;
        we_next_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    state_next_s = CALC;
                    cnt_next_s   = 5'(MULDIV_STEPS - 1);
                    busy_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                busy_next_s = 1'b1;
                if (cnt_r == 5'd0) begin
                    state_next_s = DONE;
                    done_next_s  = 1'b1;
                    we_next_s    = (rd_r != 5'd0);
                end else begin
                    cnt_next_s = cnt_r - 5'd1;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= IDLE;
            cnt_r    <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            we_r     <= 1'b0;
            result_r <= 32'd0;
            wadr_r   <= 5'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            we_r    <= we_next_s;
            if (last_s) begin
                result_r <= final_s;
                wadr_r   <= rd_r;
            end
        end
    end

    // Request capture when an operation is accepted
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_r     <= OP_MUL;
            rd_r     <= 5'd0;
            a_r      <= 32'd0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (load_s) begin
            op_r     <= op_e'(bus.Op);
            rd_r     <= bus.Rd;
            a_r      <= bus.A;
            neg_a_r  <= sign_a_s;
            neg_b_r  <= sign_b_s;
            b_zero_r <= (bus.B == 32'd0);
        end
    end

    assign bus.Busy   = busy_r;
    assign bus.Done   = done_r;
    assign bus.WE     = we_r;
    assign bus.Result = result_r;
    assign bus.WAdr   = wadr_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit -- directed bench for muldiv_unit with a cycle-level
// reference model (latency + arithmetic) compared on every falling edge.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldiv_if bus ();

    muldiv_unit dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference from plain integer operators
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_SIGNED_EN
        int     sa, sb;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        p  = longint'(sa) * longint'(sb);
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
        endcase
`else
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
`endif
    endfunction

    // Model state: edge count, active operation window, result registers
    int          ec = 0;
    bit          m_active = 1'b0;
    int          m_done_edge = 0;
    logic [31:0] m_pend = 32'd0;
    logic [4:0]  m_pend_rd = 5'd0;
    logic [31:0] m_result = 32'd0;
    logic [4:0]  m_wadr = 5'd0;

    // Model update on each rising edge (inputs are stable here)
    always @(posedge Clk) begin
        ec = ec + 1;
        if (Rst) begin
            m_active = 1'b0;
            m_result = 32'd0;
            m_wadr   = 5'd0;
        end else if (m_active) begin
            if (ec == m_done_edge + 1) begin
                m_active = 1'b0;
            end else if (ec == m_done_edge) begin
                m_result = m_pend;
                m_wadr   = m_pend_rd;
            end
        end else if (bus.Start) begin
            m_active    = 1'b1;
            m_done_edge = ec + 32;
            m_pend      = model(bus.Op, bus.A, bus.B);
            m_pend_rd   = bus.Rd;
        end
    end

    // Compare DUT outputs against the model every cycle
    always @(negedge Clk) begin
        logic exp_done;
        if (ec > 0) begin
            exp_done = m_active && (ec == m_done_edge);
            chk("cyc_busy",   32'(bus.Busy),   32'(m_active));
            chk("cyc_done",   32'(bus.Done),   32'(exp_done));
            chk("cyc_we",     32'(bus.WE),     32'(exp_done && (m_wadr != 5'd0)));
            chk("cyc_result", bus.Result,      m_result);
            chk("cyc_wadr",   32'(bus.WAdr),   32'(m_wadr));
        end
    end

    // One operation with literal expectations at cycles 2, 34 and 35
    task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input bit extra);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.Rd    = rd;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.Rd    = 5'($urandom);
        bus.Op    = 2'($urandom);
        chk({nm, "_busy_c2"}, 32'(bus.Busy), 32'd1);
        chk({nm, "_done_c2"}, 32'(bus.Done), 32'd0);
        for (int e = 2; e <= 33; e++) begin
            bus.Start = extra && (e == 10);
            @(posedge Clk); #1;
        end
        bus.Start = 1'b0;
        chk({nm, "_done_c34"}, 32'(bus.Done), 32'd1);
        chk({nm, "_we_c34"},   32'(bus.WE),   32'(rd != 5'd0));
        chk({nm, "_res_c34"},  bus.Result,    exp);
        chk({nm, "_wadr_c34"}, 32'(bus.WAdr), 32'(rd));
        chk({nm, "_busy_c34"}, 32'(bus.Busy), 32'd1);
        bus.Start = extra;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        chk({nm, "_busy_c35"}, 32'(bus.Busy), 32'd0);
        chk({nm, "_done_c35"}, 32'(bus.Done), 32'd0);
        chk({nm, "_hold_c35"}, bus.Result,    exp);
        repeat (2) begin
            @(posedge Clk); #1;
        end
        chk({nm, "_busy_idle"}, 32'(bus.Busy), 32'd0);
        chk({nm, "_hold_idle"}, bus.Result,    exp);
    endtask

    initial begin
        bit seen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bus.Start = 1'b0;
        bus.Op    = 2'b00;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.Rd    = 5'd0;
        Rst       = 1'b1;
        @(posedge Clk); #1;
        // Reset wins over a simultaneous Start
        bus.Start = 1'b1;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        bus.Rd    = 5'd2;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        Rst       = 1'b0;
        chk("rst_busy",   32'(bus.Busy),   32'd0);
        chk("rst_done",   32'(bus.Done),   32'd0);
        chk("rst_we",     32'(bus.WE),     32'd0);
        chk("rst_result", bus.Result,      32'd0);
        chk("rst_wadr",   32'(bus.WAdr),   32'd0);
        repeat (2) begin
            @(posedge Clk); #1;
        end
        chk("rst_prio_idle", 32'(bus.Busy), 32'd0);

        do_op("mul7x6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 1'b0);
`ifdef MULDIV_SIGNED_EN
        do_op("mulh_m1x2", OP_MULH, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0);
        do_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0);
        do_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1'b0);
        do_op("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1'b0);
        do_op("div_neg",   OP_DIV,  32'hFFFF_FC18, 32'd7, 5'd8, 32'hFFFF_FF72, 1'b0);
        do_op("rem_neg",   OP_REM,  32'hFFFF_FC18, 32'd7, 5'd8, 32'hFFFF_FFFA, 1'b0);
`else
        do_op("mulh_m1x2", OP_MULH, 32'hFFFF_FFFF, 32'd2, 5'd3, 32'h0000_0001, 1'b0);
        do_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0, 1'b0);
        do_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1'b0);
        do_op("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd7, 32'd1, 1'b0);
        do_op("div_neg",   OP_DIV,  32'hFFFF_FC18, 32'd7, 5'd8, 32'h2492_4895, 1'b0);
        do_op("rem_neg",   OP_REM,  32'hFFFF_FC18, 32'd7, 5'd8, 32'd5, 1'b0);
`endif
        do_op("div_by0",   OP_DIV,  32'd100, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_by0",   OP_REM,  32'd100, 32'd0, 5'd4, 32'd100, 1'b0);
        do_op("div_1000",  OP_DIV,  32'd1000, 32'd7, 5'd9, 32'd142, 1'b0);
        do_op("rem_1000",  OP_REM,  32'd1000, 32'd7, 5'd9, 32'd6, 1'b0);
        do_op("mulh_big",  OP_MULH, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 1'b0);
        do_op("restart_rd0", OP_MUL, 32'h1234_5678, 32'h0000_0010, 5'd0, 32'h2345_6780, 1'b1);

        // Reset in cycle 20 of an operation discards it
        bus.Start = 1'b1;
        bus.Op    = OP_MUL;
        bus.A     = 32'd3;
        bus.B     = 32'd5;
        bus.Rd    = 5'd9;
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        repeat (18) begin
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("midrst_busy",   32'(bus.Busy), 32'd0);
        chk("midrst_result", bus.Result,    32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge Clk); #1;
            if (bus.Done || bus.WE || bus.Busy) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        do_op("after_rst", OP_MUL, 32'd3, 32'd5, 5'd9, 32'd15, 1'b0);

        for (int i = 0; i < 4; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : $urandom;
            do_op("rand", rop, ra, rb, 5'($urandom_range(1, 31)), model(rop, ra, rb), 1'b0);
        end

        repeat (3) begin
            @(posedge Clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
